// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the ID-stage instruction description and the stall controls that
// pass between the decode pipeline and the hazard scoreboard.
//   master : pipeline side, drives the ID_* fields and Flush_i, and reads
//            back the NoOp_o / PCWrite_o / Stall_o / StallCount_o controls
//   slave  : scoreboard side, the opposite directions
// Parameters: REG_AW register index width, CNT_W stall-counter width.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              ID_Valid_i;
   logic [REG_AW-1:0] ID_Rs1_i;
   logic [REG_AW-1:0] ID_Rs2_i;
   logic              ID_Rs1Used_i;
   logic              ID_Rs2Used_i;
   logic [REG_AW-1:0] ID_Rd_i;
   logic              ID_RegWrite_i;
   logic              ID_MemRead_i;
   logic              ID_Mul_i;
   logic              Flush_i;
   logic              NoOp_o;
   logic              PCWrite_o;
   logic              Stall_o;
   logic [CNT_W-1:0]  StallCount_o;

   modport master (
      output ID_Valid_i, ID_Rs1_i, ID_Rs2_i, ID_Rs1Used_i, ID_Rs2Used_i,
             ID_Rd_i, ID_RegWrite_i, ID_MemRead_i, ID_Mul_i, Flush_i,
      input  NoOp_o, PCWrite_o, Stall_o, StallCount_o
   );

   modport slave (
      input  ID_Valid_i, ID_Rs1_i, ID_Rs2_i, ID_Rs1Used_i, ID_Rs2Used_i,
             ID_Rd_i, ID_RegWrite_i, ID_MemRead_i, ID_Mul_i, Flush_i,
      output NoOp_o, PCWrite_o, Stall_o, StallCount_o
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// ID-stage hazard unit for the 5-stage pipeline. Each architectural register
// has a countdown of cycles until its in-flight producer result can be
// forwarded; a consumer in ID stalls while its source counter is non-zero.
// Also blocks write-after-write reordering (younger op finishing first) and,
// for a non-pipelined multiplier, a new mul while the unit is busy.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active-high
//   id_if  : slave side of hazard_scoreboard_if (ID instruction in,
//            NoOp_o / PCWrite_o / Stall_o / StallCount_o out)
// Hazard outputs are combinational from the ID fields and the scoreboard.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int NUM_REGS  = 32,
   parameter int LOAD_LAT  = 1,
   parameter int MUL_LAT   = 3,
   parameter int MUL_PIPED = 0,
   parameter int CNT_W     = 16
) (
   input logic             clk_i,
   input logic             rst_i,
   hazard_scoreboard_if.slave id_if
);
   localparam int REG_AW  = $clog2(NUM_REGS);
   localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   localparam logic [CW-1:0] LOAD_LAT_C = CW'(LOAD_LAT);
   localparam logic [CW-1:0] MUL_LAT_C  = CW'(MUL_LAT);
   localparam logic [CW-1:0] MUL_BUSY_C = CW'(MUL_LAT - 1);

   logic [NUM_REGS-1:0][CW-1:0] cnt_vec;
   logic [CW-1:0]               mul_busy_reg;
   logic [CNT_W-1:0]            stall_cnt_reg;

   logic [CW-1:0]     lat;
   logic [REG_AW-1:0] rs1, rs2, rd;
   logic              raw, waw, struct_haz, hazard, issue;

   assign rs1 = id_if.ID_Rs1_i;
   assign rs2 = id_if.ID_Rs2_i;
   assign rd  = id_if.ID_Rd_i;

   // Cycles the destination of the ID instruction stays unforwardable.
   always_comb begin
      lat = '0;
      if (id_if.ID_MemRead_i)
         lat = LOAD_LAT_C;
      else if (id_if.ID_Mul_i)
         lat = MUL_LAT_C;
   end

   // cnt_vec[0] is constant zero, so x0 sources never match a pending write.
   assign raw = id_if.ID_Valid_i &
                ((id_if.ID_Rs1Used_i & (cnt_vec[rs1] != '0)) |
                 (id_if.ID_Rs2Used_i & (cnt_vec[rs2] != '0)));

   // An older producer finishing after this one would overwrite the newer value.
   assign waw = id_if.ID_Valid_i & id_if.ID_RegWrite_i & (cnt_vec[rd] > lat);

   assign struct_haz = (MUL_PIPED == 0) & id_if.ID_Valid_i & id_if.ID_Mul_i &
                       (mul_busy_reg != '0);

   // A squashed instruction never stalls: it is discarded rather than held.
   assign hazard = (raw | waw | struct_haz) & ~id_if.Flush_i;
   assign issue  = id_if.ID_Valid_i & ~hazard & ~id_if.Flush_i;

   assign id_if.NoOp_o       = hazard;
   assign id_if.Stall_o      = hazard;
   assign id_if.PCWrite_o    = ~hazard;
   assign id_if.StallCount_o = stall_cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : gen_cnt
         if (gi == 0) begin : gen_zero
            assign cnt_vec[gi] = '0;
         end else begin : gen_track
            logic [CW-1:0] cnt_reg;
            logic          load_this;

            assign load_this   = issue & id_if.ID_RegWrite_i & (rd == REG_AW'(gi));
            assign cnt_vec[gi] = cnt_reg;

            // A new producer overrides the decrement of the previous one.
            always_ff @(posedge clk_i or posedge rst_i) begin
               if (rst_i)
                  cnt_reg <= '0;
               else if (load_this)
                  cnt_reg <= lat;
               else if (cnt_reg != '0)
                  cnt_reg <= cnt_reg - 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         mul_busy_reg <= '0;
      else if (issue & id_if.ID_Mul_i)
         mul_busy_reg <= MUL_BUSY_C;
      else if (mul_busy_reg != '0)
         mul_busy_reg <= mul_busy_reg - 1'b1;
   end

   // Saturates at all-ones so a long run never wraps back to a small value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         stall_cnt_reg <= '0;
      else if (hazard && (stall_cnt_reg != '1))
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk_i = ~clk_i;

   // u0: non-pipelined multiplier, 16-bit counter. u1: pipelined, 2-bit counter.
   hazard_scoreboard_if #(.REG_AW(5), .CNT_W(16)) if0 ();
   hazard_scoreboard_if #(.REG_AW(5), .CNT_W(2))  if1 ();

   hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(1), .MUL_LAT(3), .MUL_PIPED(0), .CNT_W(16)) u0 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .id_if (if0.slave)
   );

   hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(1), .MUL_LAT(3), .MUL_PIPED(1), .CNT_W(2)) u1 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .id_if (if1.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive the same ID instruction into both scoreboards.
   task automatic drive(input logic v, input logic [4:0] r1, input logic u1r, input logic [4:0] r2,
                        input logic u2r, input logic [4:0] d, input logic rw, input logic mr,
                        input logic ml, input logic fl);
      if0.ID_Valid_i = v;   if1.ID_Valid_i = v;
      if0.ID_Rs1_i = r1;    if1.ID_Rs1_i = r1;
      if0.ID_Rs1Used_i = u1r; if1.ID_Rs1Used_i = u1r;
      if0.ID_Rs2_i = r2;    if1.ID_Rs2_i = r2;
      if0.ID_Rs2Used_i = u2r; if1.ID_Rs2Used_i = u2r;
      if0.ID_Rd_i = d;      if1.ID_Rd_i = d;
      if0.ID_RegWrite_i = rw; if1.ID_RegWrite_i = rw;
      if0.ID_MemRead_i = mr;  if1.ID_MemRead_i = mr;
      if0.ID_Mul_i = ml;    if1.ID_Mul_i = ml;
      if0.Flush_i = fl;     if1.Flush_i = fl;
      $display("drive v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d rw=%0b ld=%0b mul=%0b flush=%0b",
               v, r1, u1r, r2, u2r, d, rw, mr, ml, fl);
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      idle();
      repeat (2) cyc();
      @(negedge clk_i);
      chk("rst_noop", if0.NoOp_o, 1'b0);
      chk("rst_pcwrite", if0.PCWrite_o, 1'b1);
      chk("rst_stall", if0.Stall_o, 1'b0);
      chk("rst_count", if0.StallCount_o, 0);
      cyc();
      rst_i = 1'b0;

      // Reset asserted in the middle of a load-use stall.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);   // lw x5
      @(negedge clk_i);
      chk("t1_lw_nostall", if0.Stall_o, 1'b0);
      cyc();
      drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);   // add x6,x5,x1
      @(negedge clk_i);
      chk("t1_pre_stall", if0.Stall_o, 1'b1);
      #1 rst_i = 1'b1;
      #1;
      chk("t1_rst_noop", if0.NoOp_o, 1'b0);
      chk("t1_rst_pcwrite", if0.PCWrite_o, 1'b1);
      chk("t1_rst_stall", if0.Stall_o, 1'b0);
      chk("t1_rst_count", if0.StallCount_o, 0);
      cyc();
      rst_i = 1'b0;

      // Load-use: exactly one bubble.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);   // lw x5
      cyc();
      drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);   // add x6,x5,x1
      @(negedge clk_i);
      chk("t2_stall", if0.Stall_o, 1'b1);
      chk("t2_noop", if0.NoOp_o, 1'b1);
      chk("t2_pcwrite", if0.PCWrite_o, 1'b0);
      chk("t2_count_before", if0.StallCount_o, 0);
      cyc();
      @(negedge clk_i);
      chk("t2_release", if0.Stall_o, 1'b0);
      chk("t2_count", if0.StallCount_o, 1);
      chk("t2_count_u1", if1.StallCount_o, 1);
      cyc();

      // Multiply-use: three bubbles; independent op after mul: none.
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);   // mul x7
      cyc();
      drive(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);   // sub x8,x7,x2
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk($sformatf("t3_stall%0d", k), if0.Stall_o, 1'b1);
         cyc();
      end
      @(negedge clk_i);
      chk("t3_release", if0.Stall_o, 1'b0);
      chk("t3_count", if0.StallCount_o, 4);
      chk("t3_count_sat_u1", if1.StallCount_o, 3);
      cyc();
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);  // mul x10
      cyc();
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);   // add x9,x1,x2
      @(negedge clk_i);
      chk("t3_indep", if0.Stall_o, 1'b0);
      cyc();

      // x0 never tracked; unused source never stalls.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);   // lw x0
      cyc();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);   // add x6,x0,x0
      @(negedge clk_i);
      chk("t4_x0", if0.Stall_o, 1'b0);
      cyc();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);   // lw x5
      cyc();
      drive(1'b1, 5'd5, 1'b0, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);   // rs1=x5 unused
      @(negedge clk_i);
      chk("t4_unused", if0.Stall_o, 1'b0);
      cyc();

      // Flush: squashed load is not tracked; flush suppresses stall but cnt decays.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);   // lw x5, flushed
      @(negedge clk_i);
      chk("t5_flush_stall", if0.Stall_o, 1'b0);
      cyc();
      drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      chk("t5_after_flush", if0.Stall_o, 1'b0);
      cyc();
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);   // lw x5
      cyc();
      drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);   // use, flushed
      @(negedge clk_i);
      chk("t5_flush_hazard", if0.Stall_o, 1'b0);
      cyc();
      drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      chk("t5_decayed", if0.Stall_o, 1'b0);
      cyc();

      // WAW: load to a register with a pending mul waits until cnt <= LOAD_LAT.
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);   // mul x7
      cyc();
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);   // lw x7
      @(negedge clk_i);
      chk("waw_stall0", if0.Stall_o, 1'b1);
      cyc();
      @(negedge clk_i);
      chk("waw_stall1", if0.Stall_o, 1'b1);
      cyc();
      @(negedge clk_i);
      chk("waw_release", if0.Stall_o, 1'b0);
      chk("waw_count", if0.StallCount_o, 6);
      cyc();
      idle();
      repeat (4) cyc();

      // Back-to-back independent muls: structural stall only when not pipelined.
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);  // mul x11
      cyc();
      drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);  // mul x12
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i);
         chk($sformatf("t6_u0_stall%0d", k), if0.Stall_o, 1'b1);
         chk($sformatf("t6_u1_nostall%0d", k), if1.Stall_o, 1'b0);
         cyc();
      end
      @(negedge clk_i);
      chk("t6_u0_release", if0.Stall_o, 1'b0);
      chk("t6_u0_count", if0.StallCount_o, 8);
      chk("t6_u1_count_sat", if1.StallCount_o, 3);
      cyc();
      idle();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
